// File: rtl/weight_feature_loader.sv
// Streams one weight load then one feature load into register buffers.
// Optional beat width check: define LOADER_WIDTH_CHECK_EN.
module weight_feature_loader #(
  parameter int WEIGHT_WIDTH  = 5,
  parameter int FEATURE_WIDTH = 8,
  parameter int WEIGHT_ROWS   = 96,
  parameter int FEATURE_ROWS  = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [FEATURE_WIDTH-1:0] in_data,
  output logic                     in_ready,
  output logic [WEIGHT_WIDTH-1:0]  weights_out  [0:WEIGHT_ROWS-1],
  output logic [FEATURE_WIDTH-1:0] features_out [0:FEATURE_ROWS-1],
  output logic                     busy,
  output logic                     load_done,
  output logic                     width_err
);

  localparam int CW = (WEIGHT_ROWS > 1) ? $clog2(WEIGHT_ROWS) : 1;
  localparam int FI = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
  localparam logic [CW-1:0] W_LAST = CW'(WEIGHT_ROWS - 1);
  localparam logic [CW-1:0] F_LAST = CW'(FEATURE_ROWS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD_W = 2'd1,
    LOAD_F = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            we_w, we_f;
  logic [FI-1:0]   fidx;

  logic [WEIGHT_WIDTH-1:0]  weights_q  [0:WEIGHT_ROWS-1];
  logic [FEATURE_WIDTH-1:0] features_q [0:FEATURE_ROWS-1];

  assign fidx         = cnt_q[FI-1:0];
  assign weights_out  = weights_q;
  assign features_out = features_q;

  // State and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter advance and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    load_done = 1'b0;
    we_w      = 1'b0;
    we_f      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_W;
          cnt_d   = '0;
        end
      end
      LOAD_W: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          we_w = 1'b1;
          if (cnt_q == W_LAST) begin
            cnt_d   = '0;
            state_d = LOAD_F;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      LOAD_F: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          we_f = 1'b1;
          if (cnt_q == F_LAST) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        load_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Weight buffer: one entry written per accepted weight beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WEIGHT_ROWS; i++) weights_q[i] <= '0;
    end else if (we_w) begin
      weights_q[cnt_q] <= in_data[WEIGHT_WIDTH-1:0];
    end
  end

  // Feature buffer: one entry written per accepted feature beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FEATURE_ROWS; i++) features_q[i] <= '0;
    end else if (we_f) begin
      features_q[fidx] <= in_data;
    end
  end

`ifdef LOADER_WIDTH_CHECK_EN
  logic err_q, err_d;
  logic upper_nz;

  assign upper_nz  = (in_data >> WEIGHT_WIDTH) != '0;
  assign width_err = err_q;

  // Sticky flag: cleared by an accepted start, set by a wide weight beat.
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && start) err_d = 1'b0;
    if (we_w && upper_nz) err_d = 1'b1;
  end

  // Width error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`else
  assign width_err = 1'b0;
`endif

endmodule

// File: doc/weight_feature_loader.md
WEIGHT_FEATURE_LOADER -- requirements
Module: weight_feature_loader

Interface
REQ-001 Parameter WEIGHT_WIDTH, default 5: bit width of one weight entry.
REQ-002 Parameter FEATURE_WIDTH, default 8: bit width of one feature entry and of the input stream word.
REQ-003 Parameter WEIGHT_ROWS, default 96: number of weight entries per load.
REQ-004 Parameter FEATURE_ROWS, default 6: number of feature entries per load.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low, and the ports SHALL be named clk and rst_n.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 start  input  1  single-cycle request to begin a load.
REQ-009 in_valid  input  1  in_data carries a valid beat.
REQ-010 in_data  input  FEATURE_WIDTH  stream word; weight beats use bits [WEIGHT_WIDTH-1:0].
REQ-011 in_ready  output  1  block accepts a beat this cycle.
REQ-012 weights_out  output  unpacked array [0:WEIGHT_ROWS-1] of WEIGHT_WIDTH  weight buffer, feeds the vector multiplier scratchpad_in.
REQ-013 features_out  output  unpacked array [0:FEATURE_ROWS-1] of FEATURE_WIDTH  feature buffer, feeds the vector multiplier features_in.
REQ-014 busy  output  1  high in LOAD_W and LOAD_F.
REQ-015 load_done  output  1  one-cycle pulse when both buffers are complete.
REQ-016 width_err  output  1  sticky flag for a weight beat with nonzero upper bits (see Configuration).

Function
REQ-017 The FSM SHALL have states IDLE, LOAD_W, LOAD_F and DONE.
REQ-018 IDLE->LOAD_W on start=1; the beat counter SHALL clear to 0 on the same edge.
REQ-019 in_ready SHALL be 1 exactly in LOAD_W and LOAD_F, driven combinationally from state.
REQ-020 A beat SHALL be accepted only on a cycle with in_valid=1 and in_ready=1; in_valid=0 cycles SHALL stall with no state change.
REQ-021 In LOAD_W, accepted beat k SHALL write in_data[WEIGHT_WIDTH-1:0] to weights_out[k], which updates at the next edge.
REQ-022 After accepted weight beat WEIGHT_ROWS-1, the FSM SHALL go to LOAD_F with the counter at 0.
REQ-023 In LOAD_F, accepted beat k SHALL write in_data to features_out[k].
REQ-024 After accepted feature beat FEATURE_ROWS-1, the FSM SHALL go to DONE.
REQ-025 In DONE, load_done SHALL be 1 for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-026 start in LOAD_W, LOAD_F or DONE SHALL be ignored.
REQ-027 start in the DONE->IDLE cycle SHALL be ignored; a new start is honoured only while in IDLE.
REQ-028 Buffers SHALL hold their contents in IDLE and DONE; a new load overwrites them entry by entry.
REQ-029 The counter SHALL be ceil(log2(WEIGHT_ROWS)) bits wide and SHALL never exceed WEIGHT_ROWS-1.
REQ-030 Total latency SHALL be WEIGHT_ROWS+FEATURE_ROWS accepted beats plus 1 cycle from start to load_done with in_valid held at 1: 103 cycles at default parameters.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, counter 0, all weights_out and features_out entries 0, and busy, load_done and width_err 0.
REQ-032 Reset asserted mid-load SHALL abandon the load; no partial load_done SHALL ever be produced.

Configuration
REQ-033 With macro LOADER_WIDTH_CHECK_EN defined, width_err SHALL set when a weight beat is accepted with in_data[FEATURE_WIDTH-1:WEIGHT_WIDTH] nonzero.
REQ-034 With the macro defined, width_err SHALL stay set until the next accepted start or reset; the data SHALL still be written truncated.
REQ-035 Without the macro, width_err SHALL be tied to 0 and no check logic SHALL be present.

Verification
REQ-036 Reset, then start, then 96 beats in_data=k mod 32, then 6 beats 8'hA0+k -> weights_out[k]=k mod 32, features_out[5]=8'hA5, load_done high for one cycle at cycle 103.
REQ-037 Same load with in_valid toggling 1/0 every cycle -> identical buffer contents, load_done at cycle 205, busy high throughout.
REQ-038 start pulsed at weight beat 40 -> ignored, counter continues, load_done pulses exactly once.
REQ-039 rst_n low after 50 weight beats -> all buffers 0, IDLE, busy=0, no load_done; a following full load completes normally.
REQ-040 With LOADER_WIDTH_CHECK_EN, weight beat in_data=8'h3F -> entry=5'h1F, width_err=1 until next start; without the macro -> width_err=0.
